// File: rtl/board_io_ctrl_if.sv
// Board I/O conditioner signal bundle: raw inputs, conditioned input levels and
// pulses, and the per-LED source/mode/duty controls with the LED drive.
// The slave modport is the conditioner side; the master modport is the SoC/board side.
interface board_io_ctrl_if #(
    parameter int unsigned NUM_IN   = 8,
    parameter int unsigned NUM_LED  = 4,
    parameter int unsigned PWM_BITS = 8
);
    logic [NUM_IN-1:0]           raw_i;
    logic [NUM_IN-1:0]           in_level_o;
    logic [NUM_IN-1:0]           in_rise_o;
    logic [NUM_IN-1:0]           in_fall_o;
    logic [NUM_LED-1:0]          led_src_i;
    logic [2*NUM_LED-1:0]        led_mode_i;
    logic [PWM_BITS*NUM_LED-1:0] led_duty_i;
    logic [NUM_LED-1:0]          led_o;

    modport master (
        output raw_i, led_src_i, led_mode_i, led_duty_i,
        input  in_level_o, in_rise_o, in_fall_o, led_o
    );

    modport slave (
        input  raw_i, led_src_i, led_mode_i, led_duty_i,
        output in_level_o, in_rise_o, in_fall_o, led_o
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board-level I/O conditioner.
// Input channels: 2-FF synchroniser, debounce counter, registered level and
// one-cycle rise/fall pulses coincident with the level change.
// LED channels: registered drive in direct / blink / PWM / inverted mode.
// Optional feature macro: BOARD_IO_PWM_EN builds the PWM counter and duty
// comparators; without it mode 2'b10 drives the source level directly.
module board_io_ctrl #(
    parameter int unsigned NUM_IN          = 8,
    parameter int unsigned NUM_LED         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLINK_DIV       = 25000000,
    parameter int unsigned PWM_BITS        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    board_io_ctrl_if.slave io
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_INV    = 2'b11
    } led_mode_t;

    logic [NUM_IN-1:0]  sync1_q, sync2_q, level_q, rise_q, fall_q;
    logic [CNT_W-1:0]   db_cnt_q [NUM_IN];
    logic [BLK_W-1:0]   blink_cnt_q;
    logic               blink_phase_q;
    logic [NUM_LED-1:0] led_d, led_q;

    // Two-stage synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io.raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: accept the new level after DEBOUNCE_CYCLES
    // consecutive disagreeing cycles, pulsing rise/fall on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < NUM_IN; i++) db_cnt_q[i] <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] == CNT_LAST) begin
                        level_q[i]  <= sync2_q[i];
                        rise_q[i]   <= sync2_q[i];
                        fall_q[i]   <= ~sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Shared blink timebase: phase toggles every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLK_W'(1);
        end
    end

`ifdef BOARD_IO_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;

    // Shared free-running PWM counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
`else
    logic unused_duty;
    assign unused_duty = ^io.led_duty_i;
`endif

    // LED mode select per channel.
    always_comb begin
        led_d = '0;
        for (int unsigned k = 0; k < NUM_LED; k++) begin
            case (led_mode_t'(io.led_mode_i[2*k +: 2]))
                MODE_DIRECT: led_d[k] = io.led_src_i[k];
                MODE_BLINK:  led_d[k] = io.led_src_i[k] & blink_phase_q;
`ifdef BOARD_IO_PWM_EN
                MODE_PWM:    led_d[k] = io.led_src_i[k] &
                                        (pwm_cnt_q < io.led_duty_i[PWM_BITS*k +: PWM_BITS]);
`else
                MODE_PWM:    led_d[k] = io.led_src_i[k];
`endif
                MODE_INV:    led_d[k] = ~io.led_src_i[k];
                default:     led_d[k] = 1'b0;
            endcase
        end
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_d;
    end

    assign io.in_level_o = level_q;
    assign io.in_rise_o  = rise_q;
    assign io.in_fall_o  = fall_q;
    assign io.led_o      = led_q;
endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-level I/O conditioner for the FPGA top level, sitting between raw board pins (switches, push-buttons) and the SoC/LED nets. Replaces direct pin-to-net wiring: each input channel is synchronised, debounced and edge-detected, and each LED channel is driven in one of four run-time-selectable modes: direct, blink, PWM-dimmed or inverted. Channel counts, debounce time, blink rate and PWM resolution are parameters.

## Interface
- NUM_IN, 8: number of raw input channels (switches + buttons).
- NUM_LED, 4: number of LED channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a new input level; ≥1.
- BLINK_DIV, 25000000: blink half-period in cycles; ≥1.
- PWM_BITS, 8: PWM counter/duty width; ≥1.

- clk  in  1  system clock (clk_cpu domain).
- rst_n  in  1  asynchronous, active-low reset.
- raw_i  in  NUM_IN  asynchronous board inputs.
- in_level_o  out  NUM_IN  debounced level.
- in_rise_o  out  NUM_IN  one-cycle pulse on debounced 0→1.
- in_fall_o  out  NUM_IN  one-cycle pulse on debounced 1→0.
- led_src_i  in  NUM_LED  per-LED source level (e.g. gpio_out, pll_locked).
- led_mode_i  in  2*NUM_LED  per-LED mode, bits [2k+1:2k] for LED k.
- led_duty_i  in  PWM_BITS*NUM_LED  per-LED duty, bits [PWM_BITS*(k+1)-1:PWM_BITS*k].
- led_o  out  NUM_LED  LED drive, active high.

## Operation
- Input path, per channel: 2-FF synchroniser → debounce counter (width clog2(DEBOUNCE_CYCLES+1)) → level register.
- Each cycle: if sync output ≠ level, counter increments; else counter clears.
- When counter == DEBOUNCE_CYCLES-1 and disagreement persists at the clock edge: level flips, counter clears, matching rise/fall pulse asserted for exactly that one cycle (registered, coincident with level change).
- Disagreement shorter than DEBOUNCE_CYCLES consecutive cycles: no level change, no pulse; counter restarts on any agreement cycle.
- Channels fully independent; simultaneous changes on several channels each produce their own pulse.
- Inputs high at reset release: level rises 2+DEBOUNCE_CYCLES cycles later with a rise pulse (defined behaviour, not suppressed).
- LED path: shared free-running blink counter toggles blink_phase every BLINK_DIV cycles; shared free-running PWM counter pwm_cnt 0..2^PWM_BITS-1, wraps to 0.
- Mode 00 direct: led = src. Mode 01 blink: led = src & blink_phase. Mode 10 PWM: led = src & (pwm_cnt < duty). Mode 11 inverted: led = ~src.
- PWM: duty 0 → always off; duty 2^PWM_BITS-1 → on (2^PWM_BITS-1) of every 2^PWM_BITS cycles. Comparison unsigned.
- Mode or duty change takes effect at the next clock edge; no glitch-free handover required.

## Timing
- Reset (async assert, synchronous-release by the clk domain upstream): all sync FFs, counters, in_level_o, in_rise_o, in_fall_o, led_o, blink_phase, pwm_cnt = 0.
- rst_n low mid-debounce or mid-blink: all state cleared immediately; in-flight counts lost.
- raw_i edge → in_level_o/pulse: 2 (sync) + DEBOUNCE_CYCLES cycles.
- led_src_i/led_mode_i/led_duty_i → led_o: 1 cycle (led_o registered).
- Blink: first blink_phase high after BLINK_DIV cycles out of reset; period 2*BLINK_DIV.

## Configuration
- BOARD_IO_PWM_EN defined: PWM counter and per-LED duty comparators built; mode 10 as above.
- Undefined: no PWM logic; mode 10 behaves as mode 00 (led = src); led_duty_i ignored.

## Test plan
Bench params: NUM_IN=2, NUM_LED=2, DEBOUNCE_CYCLES=4, BLINK_DIV=3, PWM_BITS=3.
- Reset: drive activity, pull rst_n low mid-cycle → in_level_o, in_rise_o, in_fall_o, led_o all 0 without waiting for a clock edge.
- raw_i[0] 0→1 held → in_level_o[0]=1 exactly 6 cycles after first sampling edge; in_rise_o[0] high for that one cycle only; channel 1 unaffected.
- raw_i[1] high for 3 cycles then low → no level change, no pulse; 1→0 after settling high → in_fall_o[1] single pulse.
- led_mode=01, src=1 → led_o low 3 cycles, high 3, repeating; src=0 → led_o 0 constant.
- With BOARD_IO_PWM_EN, mode=10, duty=3, src=1 → led_o high 3 of every 8 cycles; duty=0 → never high; without macro → led_o constant 1.
- mode=11, src=0 → led_o=1 one cycle after mode write; both raw channels toggling simultaneously → two independent, concurrent pulses.
